// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: handshake FSM states and the EX/MEM register layout.
package mem_stage_pkg;

  localparam int MS_N             = 64;
  localparam int MS_REG_AW        = 5;
  localparam int DWORD_ALIGN_BITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // The struct widths come from the package, so N/REG_AW overrides must be mirrored here.
  typedef struct packed {
    logic                 branch;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 mem_to_reg;
    logic                 zero;
    logic                 misalign;
    logic [MS_REG_AW-1:0] rd;
    logic [MS_N-1:0]      alu_result;
    logic [MS_N-1:0]      write_data;
    logic [MS_N-1:0]      pc_branch;
  } exmem_t;

  function automatic logic is_misaligned(input logic [MS_N-1:0] addr);
    return |addr[DWORD_ALIGN_BITS-1:0];
  endfunction

endpackage

// File: rtl/dmem_req_ctrl.sv
// Data-memory request FSM: sequences IDLE/ACCESS/RESP, drives the request valid and
// upstream stall, and latches load data on the acknowledge.
module dmem_req_ctrl
  import mem_stage_pkg::*;
#(
  parameter int N = MS_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         capture,
  input  logic         cap_mem,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output state_t       state,
  output logic         dm_req,
  output logic         ex_ready,
  output logic [N-1:0] rdata
);

  state_t       state_reg, state_next;
  logic [N-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ACCESS && dm_ack) rdata_reg <= dm_rdata;
    end
  end

  // RESP behaves like IDLE for acceptance, which gives one ALU op per cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, RESP: begin
        if (capture) state_next = cap_mem ? ACCESS : RESP;
        else         state_next = IDLE;
      end
      ACCESS: if (dm_ack) state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  assign state    = state_reg;
  assign dm_req   = (state_reg == ACCESS);
  assign ex_ready = (state_reg != ACCESS);
  assign rdata    = rdata_reg;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: EX/MEM register, data-memory handshake, branch resolve and WB bundle.
// Optional MISALIGN_TRAP_EN: misaligned memory ops skip the access and raise misalign_M.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int N      = MS_N,
  parameter int REG_AW = MS_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [N-1:0]      aluResult_E,
  input  logic [N-1:0]      writeData_E,
  input  logic [N-1:0]      PCBranch_E,
  input  logic              zero_E,
  input  logic              Branch_E,
  input  logic              MemRead_E,
  input  logic              MemWrite_E,
  input  logic              RegWrite_E,
  input  logic              MemtoReg_E,
  input  logic [REG_AW-1:0] rd_E,
  output logic              dm_req,
  output logic              dm_we,
  output logic [N-1:0]      dm_addr,
  output logic [N-1:0]      dm_wdata,
  input  logic              dm_ack,
  input  logic [N-1:0]      dm_rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_rd,
  output logic [N-1:0]      wb_data,
  output logic              PCSrc_M,
  output logic [N-1:0]      PCBranch_M,
  output logic              misalign_M
);

  exmem_t       exmem_reg, exmem_next;
  state_t       state;
  logic [N-1:0] rdata;
  logic         capture, cap_misalign, cap_mem, resp, is_load;

  assign capture = ex_valid & ex_ready;

`ifdef MISALIGN_TRAP_EN
  assign cap_misalign = (MemRead_E | MemWrite_E) & is_misaligned(aluResult_E);
`else
  assign cap_misalign = 1'b0;
`endif

  assign cap_mem = (MemRead_E | MemWrite_E) & ~cap_misalign;

  always_comb begin
    exmem_next = exmem_reg;
    if (capture) begin
      exmem_next.branch     = Branch_E;
      exmem_next.mem_read   = MemRead_E;
      exmem_next.mem_write  = MemWrite_E;
      exmem_next.reg_write  = RegWrite_E;
      exmem_next.mem_to_reg = MemtoReg_E;
      exmem_next.zero       = zero_E;
      exmem_next.misalign   = cap_misalign;
      exmem_next.rd         = rd_E;
      exmem_next.alu_result = aluResult_E;
      exmem_next.write_data = writeData_E;
      exmem_next.pc_branch  = PCBranch_E;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) exmem_reg <= '0;
    else       exmem_reg <= exmem_next;
  end

  dmem_req_ctrl #(.N(N)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .cap_mem  (cap_mem),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata),
    .state    (state),
    .dm_req   (dm_req),
    .ex_ready (ex_ready),
    .rdata    (rdata)
  );

  // A store wins over a simultaneous read, so only a pure read returns memory data.
  assign is_load  = exmem_reg.mem_read & ~exmem_reg.mem_write & exmem_reg.mem_to_reg;
  assign resp     = (state == RESP);

  assign dm_we    = dm_req & exmem_reg.mem_write;
  assign dm_addr  = exmem_reg.alu_result;
  assign dm_wdata = exmem_reg.write_data;

  assign wb_valid    = resp;
  assign wb_regwrite = resp & exmem_reg.reg_write & ~exmem_reg.mem_write & ~exmem_reg.misalign;
  assign wb_rd       = resp ? exmem_reg.rd : '0;
  assign wb_data     = resp ? (is_load ? rdata : exmem_reg.alu_result) : '0;
  assign PCSrc_M     = resp & exmem_reg.branch & exmem_reg.zero;
  assign PCBranch_M  = exmem_reg.pc_branch;
  assign misalign_M  = resp & exmem_reg.misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a randomized run
// against a transaction-level model with a random-latency memory.
module tb_mem_access_stage;

  localparam int N   = 64;
  localparam int RAW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           ex_valid, ex_ready;
  logic [N-1:0]   aluResult_E, writeData_E, PCBranch_E;
  logic           zero_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [RAW-1:0] rd_E;
  logic           dm_req, dm_we, dm_ack;
  logic [N-1:0]   dm_addr, dm_wdata, dm_rdata;
  logic           wb_valid, wb_regwrite, PCSrc_M, misalign_M;
  logic [RAW-1:0] wb_rd;
  logic [N-1:0]   wb_data, PCBranch_M;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.N(N), .REG_AW(RAW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .Branch_E(Branch_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .rd_E(rd_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .misalign_M(misalign_M)
  );

  typedef struct {
    logic [RAW-1:0] rd;
    logic           rw;
    logic [N-1:0]   data;
    logic           pcsrc;
    logic [N-1:0]   pcb;
    logic           mis;
    logic           is_load;
  } exp_t;

  exp_t q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
    zero_E = 0; Branch_E = 0; MemRead_E = 0; MemWrite_E = 0; RegWrite_E = 0; MemtoReg_E = 0;
    rd_E = '0; dm_ack = 0; dm_rdata = '0;
  endtask

  task automatic present(input logic [RAW-1:0] rd, input logic [N-1:0] alu, input logic [N-1:0] wd,
                         input logic [N-1:0] pcb, input logic zero, input logic br, input logic mr,
                         input logic mw, input logic rw, input logic m2r);
    rd_E = rd; aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb; zero_E = zero;
    Branch_E = br; MemRead_E = mr; MemWrite_E = mw; RegWrite_E = rw; MemtoReg_E = m2r;
    ex_valid = 1;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    repeat (3) step();
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
    total++; if ({dm_req, dm_we, wb_valid, wb_regwrite, PCSrc_M, misalign_M} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {dm_req, dm_we, wb_valid, wb_regwrite, PCSrc_M, misalign_M});
    end
    total++; if ({dm_addr, dm_wdata, wb_data, PCBranch_M, wb_rd} !== '0) begin
      bad++; $display("FAIL reset_data: got %h %h %h %h %h want all 0", dm_addr, dm_wdata, wb_data, PCBranch_M, wb_rd);
    end
    reset = 0;
    step();
    $display("reset: done");
  endtask

  task automatic test_alu();
    present(5'd3, 64'h2A, 64'h0, 64'h0, 0, 0, 0, 0, 1, 0);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_pre_valid: got %b want 0", wb_valid); end
    step();
    ex_valid = 0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wb_valid: got %b want 1", wb_valid); end
    total++; if (wb_rd !== 5'd3) begin bad++; $display("FAIL alu_wb_rd: got %0d want 3", wb_rd); end
    total++; if (wb_data !== 64'h2A) begin bad++; $display("FAIL alu_wb_data: got %h want 2a", wb_data); end
    total++; if (wb_regwrite !== 1'b1) begin bad++; $display("FAIL alu_regwrite: got %b want 1", wb_regwrite); end
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_pulse: got %b want 0", wb_valid); end
    $display("alu: rd=3 data=%h", 64'h2A);
  endtask

  task automatic test_load();
    int low_cnt;
    low_cnt = 0;
    present(5'd5, 64'h100, 64'h0, 64'h0, 0, 0, 1, 0, 1, 1);
    step();
    ex_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (ex_ready === 1'b0) low_cnt++;
      total++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 64'h100) begin
        bad++; $display("FAIL load_req: got req=%b we=%b addr=%h want 1 0 100", dm_req, dm_we, dm_addr);
      end
      if (i == 2) begin dm_ack = 1; dm_rdata = 64'hDEAD; end
      step();
    end
    dm_ack = 0;
    total++; if (low_cnt !== 3) begin bad++; $display("FAIL load_stall: got %0d want 3", low_cnt); end
    total++; if (wb_valid !== 1'b1 || wb_data !== 64'hDEAD || wb_rd !== 5'd5 || wb_regwrite !== 1'b1) begin
      bad++; $display("FAIL load_wb: got v=%b data=%h rd=%0d rw=%b want 1 dead 5 1", wb_valid, wb_data, wb_rd, wb_regwrite);
    end
    total++; if (ex_ready !== 1'b1 || dm_req !== 1'b0) begin
      bad++; $display("FAIL load_release: got ready=%b req=%b want 1 0", ex_ready, dm_req);
    end
    step();
    $display("load: addr=100 data=%h", 64'hDEAD);
  endtask

  task automatic test_store();
    present(5'd9, 64'h108, 64'h55, 64'h0, 0, 0, 0, 1, 1, 0);
    step();
    ex_valid = 0;
    dm_ack = 1;
    total++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 64'h55 || dm_addr !== 64'h108) begin
      bad++; $display("FAIL store_req: got req=%b we=%b wdata=%h addr=%h want 1 1 55 108", dm_req, dm_we, dm_wdata, dm_addr);
    end
    step();
    dm_ack = 0;
    total++; if (wb_valid !== 1'b1 || wb_regwrite !== 1'b0 || dm_req !== 1'b0) begin
      bad++; $display("FAIL store_wb: got v=%b rw=%b req=%b want 1 0 0", wb_valid, wb_regwrite, dm_req);
    end
    step();
    $display("store: addr=108 data=55");
  endtask

  task automatic test_branch();
    present(5'd0, 64'h0, 64'h0, 64'h40, 1, 1, 0, 0, 0, 0);
    step();
    ex_valid = 0;
    total++; if (PCSrc_M !== 1'b1 || PCBranch_M !== 64'h40 || wb_valid !== 1'b1) begin
      bad++; $display("FAIL cbz_taken: got pcsrc=%b pcb=%h v=%b want 1 40 1", PCSrc_M, PCBranch_M, wb_valid);
    end
    step();
    total++; if (PCSrc_M !== 1'b0 || PCBranch_M !== 64'h40) begin
      bad++; $display("FAIL cbz_hold: got pcsrc=%b pcb=%h want 0 40", PCSrc_M, PCBranch_M);
    end
    present(5'd0, 64'h1, 64'h0, 64'h80, 0, 1, 0, 0, 0, 0);
    step();
    ex_valid = 0;
    total++; if (PCSrc_M !== 1'b0 || PCBranch_M !== 64'h80 || wb_valid !== 1'b1) begin
      bad++; $display("FAIL cbz_not_taken: got pcsrc=%b pcb=%h v=%b want 0 80 1", PCSrc_M, PCBranch_M, wb_valid);
    end
    step();
    $display("branch: taken and not-taken");
  endtask

  task automatic test_reset_mid_access();
    present(5'd6, 64'h200, 64'h0, 64'h0, 0, 0, 1, 0, 1, 1);
    step();
    ex_valid = 0;
    total++; if (dm_req !== 1'b1) begin bad++; $display("FAIL rst_access_req: got %b want 1", dm_req); end
    step();
    reset = 1;
    step();
    total++; if (dm_req !== 1'b0 || ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL rst_access_abort: got req=%b ready=%b v=%b want 0 1 0", dm_req, ex_ready, wb_valid);
    end
    reset = 0;
    dm_ack = 1;
    dm_rdata = 64'hBAD;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (wb_valid !== 1'b0 || dm_req !== 1'b0) begin
        bad++; $display("FAIL rst_stray_ack: got v=%b req=%b want 0 0", wb_valid, dm_req);
      end
    end
    dm_ack = 0;
    $display("reset_mid_access: op discarded");
  endtask

  task automatic test_misalign();
    present(5'd7, 64'h103, 64'h0, 64'h0, 0, 0, 1, 0, 1, 1);
    step();
    ex_valid = 0;
`ifdef MISALIGN_TRAP_EN
    total++; if (dm_req !== 1'b0 || misalign_M !== 1'b1 || wb_valid !== 1'b1 || wb_regwrite !== 1'b0) begin
      bad++; $display("FAIL misalign_trap: got req=%b mis=%b v=%b rw=%b want 0 1 1 0", dm_req, misalign_M, wb_valid, wb_regwrite);
    end
    step();
    total++; if (dm_req !== 1'b0 || misalign_M !== 1'b0) begin
      bad++; $display("FAIL misalign_after: got req=%b mis=%b want 0 0", dm_req, misalign_M);
    end
`else
    total++; if (dm_req !== 1'b1 || dm_addr !== 64'h103 || misalign_M !== 1'b0) begin
      bad++; $display("FAIL misalign_pass: got req=%b addr=%h mis=%b want 1 103 0", dm_req, dm_addr, misalign_M);
    end
    dm_ack = 1;
    dm_rdata = 64'h77;
    step();
    dm_ack = 0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 64'h77 || misalign_M !== 1'b0) begin
      bad++; $display("FAIL misalign_pass_wb: got v=%b data=%h mis=%b want 1 77 0", wb_valid, wb_data, misalign_M);
    end
`endif
    step();
    $display("misalign: addr=103");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] alu;
    for (int i = 0; i < 6; i++) begin
      alu = {$urandom, $urandom};
      present(RAW'(i + 1), alu, 64'h0, 64'h0, 0, 0, 0, 0, 1, 0);
      step();
      total++; if (wb_valid !== 1'b1 || wb_rd !== RAW'(i + 1) || wb_data !== alu || ex_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d: got v=%b rd=%0d data=%h ready=%b want 1 %0d %h 1", i, wb_valid, wb_rd, wb_data, ex_ready, i + 1, alu);
      end
    end
    ex_valid = 0;
    step();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", wb_valid); end
    $display("back_to_back: 6 ops");
  endtask

  task automatic test_random();
    bit exp_access, exp_wb, ack_now, cap_now, cap_access, mem, mis;
    int delay, kind;
    logic [N-1:0] cur_addr, cur_wdata;
    logic cur_we, br, mr, mw, rw, m2r, zero;
    logic [N-1:0] alu, wd, pcb;
    logic [RAW-1:0] rd;
    exp_t e;
    exp_access = 0; ack_now = 0; cap_now = 0; cap_access = 0; delay = 0;
    cur_addr = '0; cur_wdata = '0; cur_we = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_wb = 0;
      dm_ack = 0;
      if (ack_now) begin exp_access = 0; exp_wb = 1; ack_now = 0; end
      if (cap_now) begin
        cap_now = 0;
        ex_valid = 0;
        if (cap_access) begin exp_access = 1; delay = $urandom_range(0, 3); end
        else exp_wb = 1;
      end
      total++; if (dm_req !== exp_access) begin bad++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, dm_req, exp_access); end
      if (exp_access) begin
        total++; if (dm_we !== cur_we || dm_addr !== cur_addr || dm_wdata !== cur_wdata) begin
          bad++; $display("FAIL rnd_dm c%0d: got we=%b addr=%h wdata=%h want %b %h %h", cyc, dm_we, dm_addr, dm_wdata, cur_we, cur_addr, cur_wdata);
        end
      end
      total++; if (wb_valid !== exp_wb) begin bad++; $display("FAIL rnd_wb_valid c%0d: got %b want %b", cyc, wb_valid, exp_wb); end
      if (exp_wb && q.size() > 0) begin
        e = q.pop_front();
        total++; if (wb_rd !== e.rd || wb_regwrite !== e.rw || PCSrc_M !== e.pcsrc || misalign_M !== e.mis || PCBranch_M !== e.pcb) begin
          bad++; $display("FAIL rnd_wb c%0d: got rd=%0d rw=%b pcsrc=%b mis=%b pcb=%h want %0d %b %b %b %h",
                          cyc, wb_rd, wb_regwrite, PCSrc_M, misalign_M, PCBranch_M, e.rd, e.rw, e.pcsrc, e.mis, e.pcb);
        end
        if (e.rw) begin
          total++; if (wb_data !== e.data) begin bad++; $display("FAIL rnd_wb_data c%0d: got %h want %h", cyc, wb_data, e.data); end
        end
        $display("rnd c%0d: wb rd=%0d rw=%b data=%h", cyc, wb_rd, wb_regwrite, wb_data);
      end
      total++; if (ex_ready !== !exp_access) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, ex_ready, !exp_access); end
      dm_rdata = {$urandom, $urandom};
      if (exp_access) begin
        if (delay == 0) begin
          dm_ack = 1;
          if (q[q.size()-1].is_load) q[q.size()-1].data = dm_rdata;
          ack_now = 1;
        end else delay--;
      end else begin
        dm_ack = ($urandom_range(0, 3) == 0);
      end
      if (!exp_access && $urandom_range(0, 3) != 0) begin
        kind = $urandom_range(0, 3);
        alu = {$urandom, $urandom}; wd = {$urandom, $urandom}; pcb = {$urandom, $urandom};
        rd = RAW'($urandom); zero = 1'($urandom);
        br = 0; mr = 0; mw = 0; rw = 0; m2r = 0;
        case (kind)
          0: rw = 1;
          1: begin mr = 1; m2r = 1; rw = 1; end
          2: begin mw = 1; mr = 1'($urandom); rw = 1'($urandom); end
          default: br = 1;
        endcase
        mem = mr | mw;
        if (mem && $urandom_range(0, 4) != 0) alu[2:0] = 3'b000;
`ifdef MISALIGN_TRAP_EN
        mis = mem && (alu[2:0] != 3'b000);
`else
        mis = 0;
`endif
        e.rd = rd; e.rw = rw & !mw & !mis; e.data = alu; e.pcsrc = br & zero;
        e.pcb = pcb; e.mis = mis; e.is_load = (kind == 1) && !mis;
        q.push_back(e);
        cap_now = 1; cap_access = mem && !mis;
        cur_addr = alu; cur_wdata = wd; cur_we = mw;
        present(rd, alu, wd, pcb, zero, br, mr, mw, rw, m2r);
      end
      step();
    end
    ex_valid = 0;
    dm_ack = 0;
    q.delete();
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_reset_mid_access();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
